// File: rtl/hazard_pkg.sv
// Shared encodings and helpers for the Tnew-based hazard pipeline.
// Forward-select codes, register/Tnew widths and the saturating Tnew decrement.
package hazard_pkg;

  localparam int A_W = 5;
  localparam int T_W = 2;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_E   = 2'd1,
    FWD_M   = 2'd2,
    FWD_W   = 2'd3
  } fwd_e;

  localparam logic [T_W-1:0] TNEW_0 = T_W'(0);
  localparam logic [T_W-1:0] TNEW_1 = T_W'(1);
  localparam logic [T_W-1:0] TNEW_2 = T_W'(2);

  // Tnew counts down one per stage and stops at zero; it never wraps.
  function automatic logic [T_W-1:0] sat_dec(input logic [T_W-1:0] t);
    return (t == TNEW_0) ? TNEW_0 : t - TNEW_1;
  endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// One pipeline slot holding a destination register and its remaining Tnew.
// A bubble clears the slot; DEC selects whether Tnew is decremented on entry.
module hazard_stage_reg
  import hazard_pkg::*;
#(
  parameter int A_W = hazard_pkg::A_W,
  parameter int T_W = hazard_pkg::T_W,
  parameter bit DEC = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           bubble,
  input  logic [A_W-1:0] src_a3,
  input  logic [T_W-1:0] src_tnew,
  output logic [A_W-1:0] a3,
  output logic [T_W-1:0] tnew
);

  // NOTE: non-blocking assignments let every stage sample its predecessor's
  // pre-edge value, so the pipeline shifts by exactly one slot per clock.
  always_ff @(posedge clk) begin
    if (reset || bubble) begin
      a3   <= '0;
      tnew <= '0;
    end else begin
      a3   <= src_a3;
      tnew <= DEC ? sat_dec(src_tnew) : src_tnew;
    end
  end

endmodule

// File: rtl/hazard_tnew_pipe.sv
// Producer side of the hazard protocol: carries (a3, Tnew) through E/M/W and
// derives the D- and E-stage forwarding selects, youngest producer first.
module hazard_tnew_pipe
  import hazard_pkg::*;
#(
  parameter int A_W = hazard_pkg::A_W,
  parameter int T_W = hazard_pkg::T_W
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           stall,
  input  logic [A_W-1:0] D_a1,
  input  logic [A_W-1:0] D_a2,
  input  logic [A_W-1:0] D_a3,
  input  logic [T_W-1:0] D_Tnew,
  output logic [A_W-1:0] E_a1,
  output logic [A_W-1:0] E_a2,
  output logic [A_W-1:0] E_a3,
  output logic [T_W-1:0] E_Tnew,
  output logic [A_W-1:0] M_a3,
  output logic [T_W-1:0] M_Tnew,
  output logic [A_W-1:0] W_a3,
  output logic [T_W-1:0] W_Tnew,
  output logic [1:0]     D_fwd1,
  output logic [1:0]     D_fwd2,
  output logic [1:0]     E_fwd1,
  output logic [1:0]     E_fwd2
);

  // E takes D's Tnew as-is; the decrement happens on the way into M and W.
  hazard_stage_reg #(.A_W(A_W), .T_W(T_W), .DEC(1'b0)) u_e (
    .clk(clk), .reset(reset), .bubble(stall),
    .src_a3(D_a3), .src_tnew(D_Tnew), .a3(E_a3), .tnew(E_Tnew)
  );

  hazard_stage_reg #(.A_W(A_W), .T_W(T_W), .DEC(1'b1)) u_m (
    .clk(clk), .reset(reset), .bubble(1'b0),
    .src_a3(E_a3), .src_tnew(E_Tnew), .a3(M_a3), .tnew(M_Tnew)
  );

  hazard_stage_reg #(.A_W(A_W), .T_W(T_W), .DEC(1'b1)) u_w (
    .clk(clk), .reset(reset), .bubble(1'b0),
    .src_a3(M_a3), .src_tnew(M_Tnew), .a3(W_a3), .tnew(W_Tnew)
  );

  always_ff @(posedge clk) begin
    if (reset || stall) begin
      E_a1 <= '0;
      E_a2 <= '0;
    end else begin
      E_a1 <= D_a1;
      E_a2 <= D_a2;
    end
  end

  // A matching stage with Tnew != 0 stops the search: the value is not ready
  // and an older copy of the register would be stale.
  function automatic fwd_e select(
    input logic [A_W-1:0] addr,
    input logic           use_e,
    input logic [A_W-1:0] e_a3,
    input logic [T_W-1:0] e_tnew,
    input logic [A_W-1:0] m_a3,
    input logic [T_W-1:0] m_tnew,
    input logic [A_W-1:0] w_a3
  );
    fwd_e sel;
    sel = FWD_REG;
    if (addr != '0) begin
      if (use_e && addr == e_a3) begin
        sel = (e_tnew == '0) ? FWD_E : FWD_REG;
      end else if (addr == m_a3) begin
        sel = (m_tnew == '0) ? FWD_M : FWD_REG;
      end else if (addr == w_a3) begin
        sel = FWD_W;
      end
    end
    return sel;
  endfunction

  fwd_e d_sel1, d_sel2, e_sel1, e_sel2;

  always_comb begin
    // NOTE: every output of this block is assigned first so no path can
    // leave a value held over, which would infer a latch.
    d_sel1 = FWD_REG;
    d_sel2 = FWD_REG;
    e_sel1 = FWD_REG;
    e_sel2 = FWD_REG;
    d_sel1 = select(D_a1, 1'b1, E_a3, E_Tnew, M_a3, M_Tnew, W_a3);
    d_sel2 = select(D_a2, 1'b1, E_a3, E_Tnew, M_a3, M_Tnew, W_a3);
    e_sel1 = select(E_a1, 1'b0, E_a3, E_Tnew, M_a3, M_Tnew, W_a3);
    e_sel2 = select(E_a2, 1'b0, E_a3, E_Tnew, M_a3, M_Tnew, W_a3);
  end

  assign D_fwd1 = d_sel1;
  assign D_fwd2 = d_sel2;
  assign E_fwd1 = e_sel1;
  assign E_fwd2 = e_sel2;

endmodule

// File: tb/tb_hazard_tnew_pipe.sv
// Bench for hazard_tnew_pipe: hand-computed vector table for the protocol
// corner cases, then random streams checked against a stage-list model.
module tb_hazard_tnew_pipe;

  logic       clk;
  logic       reset;
  logic       stall;
  logic [4:0] d_a1, d_a2, d_a3;
  logic [1:0] d_tnew;
  logic [4:0] e_a1, e_a2, e_a3, m_a3, w_a3;
  logic [1:0] e_tnew, m_tnew, w_tnew;
  logic [1:0] d_fwd1, d_fwd2, e_fwd1, e_fwd2;

  int checks = 0;
  int errors = 0;

  hazard_tnew_pipe dut (
    .clk(clk), .reset(reset), .stall(stall),
    .D_a1(d_a1), .D_a2(d_a2), .D_a3(d_a3), .D_Tnew(d_tnew),
    .E_a1(e_a1), .E_a2(e_a2), .E_a3(e_a3), .E_Tnew(e_tnew),
    .M_a3(m_a3), .M_Tnew(m_tnew), .W_a3(w_a3), .W_Tnew(w_tnew),
    .D_fwd1(d_fwd1), .D_fwd2(d_fwd2), .E_fwd1(e_fwd1), .E_fwd2(e_fwd2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs applied for one cycle, and the outputs expected while they are
  // applied (registered values reflect the previous vectors only).
  typedef struct {
    bit rst, stl;
    int a1, a2, a3, t;
    int ea1, ea2, ea3, et, ma3, mt, wa3, wt;
    int d1, d2, e1, e2;
  } vec_t;

  function automatic vec_t mk(bit rst, bit stl, int a1, int a2, int a3, int t,
                              int ea1, int ea2, int ea3, int et,
                              int ma3, int mt, int wa3, int wt,
                              int d1, int d2, int e1, int e2);
    vec_t v;
    v.rst = rst; v.stl = stl; v.a1 = a1; v.a2 = a2; v.a3 = a3; v.t = t;
    v.ea1 = ea1; v.ea2 = ea2; v.ea3 = ea3; v.et = et;
    v.ma3 = ma3; v.mt = mt; v.wa3 = wa3; v.wt = wt;
    v.d1 = d1; v.d2 = d2; v.e1 = e1; v.e2 = e2;
    return v;
  endfunction

  task automatic check_all(input string tag, input int ea1, input int ea2,
                           input int ea3, input int et, input int ma3, input int mt,
                           input int wa3, input int wt, input int d1, input int d2,
                           input int e1, input int e2);
    check({tag, " E_a1"}, e_a1, ea1);
    check({tag, " E_a2"}, e_a2, ea2);
    check({tag, " E_a3"}, e_a3, ea3);
    check({tag, " E_Tnew"}, e_tnew, et);
    check({tag, " M_a3"}, m_a3, ma3);
    check({tag, " M_Tnew"}, m_tnew, mt);
    check({tag, " W_a3"}, w_a3, wa3);
    check({tag, " W_Tnew"}, w_tnew, wt);
    check({tag, " D_fwd1"}, d_fwd1, d1);
    check({tag, " D_fwd2"}, d_fwd2, d2);
    check({tag, " E_fwd1"}, e_fwd1, e1);
    check({tag, " E_fwd2"}, e_fwd2, e2);
  endtask

  // Reference model: slot 0 = E, 1 = M, 2 = W.
  typedef struct {
    int a1, a2, a3, t;
  } slot_t;

  slot_t pipe [3];

  function automatic int model_fwd(input int addr, input int first);
    if (addr == 0) return 0;
    for (int s = first; s < 3; s++) begin
      if (pipe[s].a3 == addr) begin
        // W always holds a finished value; E and M only when Tnew has hit 0.
        if (s == 2 || pipe[s].t == 0) return s + 1;
        return 0;
      end
    end
    return 0;
  endfunction

  task automatic model_clock(input bit rst, input bit stl, input int a1,
                             input int a2, input int a3, input int t);
    if (rst) begin
      for (int s = 0; s < 3; s++) pipe[s] = '{0, 0, 0, 0};
    end else begin
      pipe[2] = '{0, 0, pipe[1].a3, (pipe[1].t > 0) ? pipe[1].t - 1 : 0};
      pipe[1] = '{0, 0, pipe[0].a3, (pipe[0].t > 0) ? pipe[0].t - 1 : 0};
      pipe[0] = stl ? '{0, 0, 0, 0} : '{a1, a2, a3, t};
    end
  endtask

  vec_t vecs [26];

  initial begin
    // reset mid-stream, then lw-like producer reaching W
    vecs[0]  = mk(0,0, 0,0,8,2,   0,0,0,0,  0,0,0,0,  0,0,0,0);
    vecs[1]  = mk(1,0, 0,0,8,2,   0,0,8,2,  0,0,0,0,  0,0,0,0);
    vecs[2]  = mk(0,0, 8,8,0,0,   0,0,0,0,  0,0,0,0,  0,0,0,0);
    vecs[3]  = mk(0,0, 0,0,8,2,   8,8,0,0,  0,0,0,0,  0,0,0,0);
    vecs[4]  = mk(0,0, 8,0,0,0,   0,0,8,2,  0,0,0,0,  0,0,0,0);
    vecs[5]  = mk(0,0, 8,0,0,0,   8,0,0,0,  8,1,0,0,  0,0,0,0);
    vecs[6]  = mk(0,0, 8,0,0,0,   8,0,0,0,  0,0,8,0,  3,0,3,0);
    // ALU producer, consumer one behind
    vecs[7]  = mk(0,0, 0,0,9,1,   8,0,0,0,  0,0,0,0,  0,0,0,0);
    vecs[8]  = mk(0,0, 0,9,0,0,   0,0,9,1,  0,0,0,0,  0,0,0,0);
    vecs[9]  = mk(0,0, 0,0,0,0,   0,9,0,0,  9,0,0,0,  0,0,0,2);
    // jal-like producer with Tnew 0
    vecs[10] = mk(0,0, 0,0,31,0,  0,0,0,0,  0,0,9,0,  0,0,0,0);
    vecs[11] = mk(0,0, 31,0,0,0,  0,0,31,0, 0,0,0,0,  1,0,0,0);
    // stall bubble while E holds a producer
    vecs[12] = mk(0,0, 0,0,6,2,   31,0,0,0, 31,0,0,0, 0,0,2,0);
    vecs[13] = mk(0,1, 0,0,5,1,   0,0,6,2,  0,0,31,0, 0,0,0,0);
    vecs[14] = mk(0,0, 0,0,0,0,   0,0,0,0,  6,1,0,0,  0,0,0,0);
    // reg 4 produced twice: youngest wins
    vecs[15] = mk(0,0, 0,0,4,1,   0,0,0,0,  0,0,6,0,  0,0,0,0);
    vecs[16] = mk(0,0, 0,0,4,0,   0,0,4,1,  0,0,0,0,  0,0,0,0);
    vecs[17] = mk(0,0, 4,0,0,0,   0,0,4,0,  4,0,0,0,  1,0,0,0);
    vecs[18] = mk(0,0, 0,0,0,0,   4,0,0,0,  4,0,4,0,  0,0,2,0);
    vecs[19] = mk(0,0, 4,0,0,0,   0,0,0,0,  0,0,4,0,  3,0,0,0);
    vecs[20] = mk(0,0, 0,0,0,0,   4,0,0,0,  0,0,0,0,  0,0,0,0);
    // Tnew 3 saturates down through the stages
    vecs[21] = mk(0,0, 0,0,7,3,   0,0,0,0,  0,0,0,0,  0,0,0,0);
    vecs[22] = mk(0,0, 0,0,0,0,   0,0,7,3,  0,0,0,0,  0,0,0,0);
    vecs[23] = mk(0,0, 0,0,0,0,   0,0,0,0,  7,2,0,0,  0,0,0,0);
    vecs[24] = mk(0,0, 7,0,0,0,   0,0,0,0,  0,0,7,1,  3,0,0,0);
    vecs[25] = mk(0,0, 0,0,0,0,   7,0,0,0,  0,0,0,0,  0,0,0,0);

    reset = 1'b1; stall = 1'b0;
    d_a1 = '0; d_a2 = '0; d_a3 = '0; d_tnew = '0;
    @(negedge clk);
    @(negedge clk);

    for (int i = 0; i < 26; i++) begin
      reset  = vecs[i].rst;
      stall  = vecs[i].stl;
      d_a1   = 5'(vecs[i].a1);
      d_a2   = 5'(vecs[i].a2);
      d_a3   = 5'(vecs[i].a3);
      d_tnew = 2'(vecs[i].t);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].ea1, vecs[i].ea2, vecs[i].ea3,
                vecs[i].et, vecs[i].ma3, vecs[i].mt, vecs[i].wa3, vecs[i].wt,
                vecs[i].d1, vecs[i].d2, vecs[i].e1, vecs[i].e2);
      @(negedge clk);
    end

    // Random streams over a small register set so matches are frequent.
    reset = 1'b1; stall = 1'b0;
    @(posedge clk);
    model_clock(1'b1, 1'b0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      reset  = ($urandom_range(0, 39) == 0);
      stall  = ($urandom_range(0, 3) == 0);
      d_a1   = 5'($urandom_range(0, 7));
      d_a2   = 5'($urandom_range(0, 7));
      d_a3   = 5'($urandom_range(0, 7));
      d_tnew = 2'($urandom_range(0, 3));
      #1;
      check_all($sformatf("rnd%0d", i), pipe[0].a1, pipe[0].a2, pipe[0].a3,
                pipe[0].t, pipe[1].a3, pipe[1].t, pipe[2].a3, pipe[2].t,
                model_fwd(int'(d_a1), 0), model_fwd(int'(d_a2), 0),
                model_fwd(pipe[0].a1, 1), model_fwd(pipe[0].a2, 1));
      @(posedge clk);
      model_clock(reset, stall, int'(d_a1), int'(d_a2), int'(d_a3), int'(d_tnew));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
